// File: rtl/btb_assoc_lru.sv
// Fully-associative branch target buffer with true-LRU replacement and a registered 1-cycle lookup.
// Build option: define BTB_DIRCTR_EN for per-entry 2-bit direction counters (otherwise hit implies taken).
module btb_assoc_lru #(
    parameter int ENTRIES  = 4,
    parameter int TAG_W    = 8,
    parameter int TARGET_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                lookup_valid,
    input  logic [TAG_W-1:0]    lookup_pc,
    output logic                pred_valid,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [TARGET_W-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [TAG_W-1:0]    upd_pc,
    input  logic                upd_taken,
    input  logic [TARGET_W-1:0] upd_target
);
    localparam int IW = $clog2(ENTRIES);
    typedef logic [IW-1:0] idx_t;
    typedef logic [ENTRIES-1:0][IW-1:0] rank_vec_t;

    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [ENTRIES-1:0][TARGET_W-1:0]  target_q, target_d;
    rank_vec_t                         rank_q, rank_d;
`ifdef BTB_DIRCTR_EN
    logic [ENTRIES-1:0][1:0]           ctr_q, ctr_d;
`endif
    logic                pred_valid_q, pred_hit_q, pred_taken_q;
    logic [TARGET_W-1:0] pred_target_q;

    logic [ENTRIES-1:0] lk_match, up_match;
    logic               lk_any, up_any, any_free, lk_taken;
    idx_t               lk_idx, up_idx, free_idx, lru_idx, alloc_idx;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign lk_match[gi] = valid_q[gi] && (tag_q[gi] == lookup_pc);
            assign up_match[gi] = valid_q[gi] && (tag_q[gi] == upd_pc);
        end
    endgenerate

    // Descending scan so the lowest index wins for the free-slot search.
    always_comb begin
        lk_any   = 1'b0;
        up_any   = 1'b0;
        any_free = 1'b0;
        lk_idx   = '0;
        up_idx   = '0;
        free_idx = '0;
        lru_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                lk_any = 1'b1;
                lk_idx = idx_t'(i);
            end
            if (up_match[i]) begin
                up_any = 1'b1;
                up_idx = idx_t'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = idx_t'(i);
            end
            if (rank_q[i] == idx_t'(ENTRIES - 1)) lru_idx = idx_t'(i);
        end
        alloc_idx = any_free ? free_idx : lru_idx;
    end

    function automatic rank_vec_t promote(input rank_vec_t r, input idx_t p);
        rank_vec_t res;
        res = r;
        for (int i = 0; i < ENTRIES; i++) begin
            if (idx_t'(i) == p)  res[i] = '0;
            else if (r[i] < r[p]) res[i] = r[i] + idx_t'(1);
        end
        return res;
    endfunction

`ifdef BTB_DIRCTR_EN
    assign lk_taken = ctr_q[lk_idx][1];
`else
    assign lk_taken = 1'b1;
`endif

    // Lookup promotion is applied before update promotion so the written entry ends MRU.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        rank_d   = rank_q;
`ifdef BTB_DIRCTR_EN
        ctr_d    = ctr_q;
`endif
        if (flush) begin
            valid_d = '0;
        end else begin
            if (lookup_valid && lk_any) rank_d = promote(rank_d, lk_idx);
            if (upd_valid && up_any) begin
`ifdef BTB_DIRCTR_EN
                if (upd_taken) begin
                    target_d[up_idx] = upd_target;
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
                rank_d = promote(rank_d, up_idx);
`else
                if (upd_taken) begin
                    target_d[up_idx] = upd_target;
                    rank_d = promote(rank_d, up_idx);
                end else begin
                    valid_d[up_idx] = 1'b0;
                end
`endif
            end else if (upd_valid && upd_taken) begin
                valid_d[alloc_idx]  = 1'b1;
                tag_d[alloc_idx]    = upd_pc;
                target_d[alloc_idx] = upd_target;
`ifdef BTB_DIRCTR_EN
                ctr_d[alloc_idx]    = 2'b10;
`endif
                rank_d = promote(rank_d, alloc_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                rank_q[i] <= idx_t'(i);
`ifdef BTB_DIRCTR_EN
                ctr_q[i]  <= 2'b01;
`endif
            end
        end else begin
            valid_q       <= valid_d;
            rank_q        <= rank_d;
`ifdef BTB_DIRCTR_EN
            ctr_q         <= ctr_d;
`endif
            pred_valid_q  <= lookup_valid;
            pred_hit_q    <= lookup_valid && lk_any;
            pred_taken_q  <= lookup_valid && lk_any && lk_taken;
            pred_target_q <= (lookup_valid && lk_any) ? target_q[lk_idx] : '0;
        end
    end

    // Tag and target payload need no reset; valid bits gate them.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_assoc_lru.sv
// Bench for btb_assoc_lru: a queue-based LRU model checked every cycle, plus literal expectations.
module tb_btb_assoc_lru;
    localparam int ENTRIES  = 4;
    localparam int TAG_W    = 8;
    localparam int TARGET_W = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                flush = 1'b0;
    logic                lookup_valid = 1'b0;
    logic [TAG_W-1:0]    lookup_pc = '0;
    logic                upd_valid = 1'b0;
    logic [TAG_W-1:0]    upd_pc = '0;
    logic                upd_taken = 1'b0;
    logic [TARGET_W-1:0] upd_target = '0;
    logic                pred_valid, pred_hit, pred_taken;
    logic [TARGET_W-1:0] pred_target;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btb_assoc_lru #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .TARGET_W(TARGET_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: entry contents plus a recency list, most recently used first.
    bit          m_valid [ENTRIES];
    logic [7:0]  m_tag   [ENTRIES];
    logic [31:0] m_target[ENTRIES];
    int          m_ctr   [ENTRIES];
    int          lru[$];
    logic        e_valid = 0, e_hit = 0, e_taken = 0;
    logic [31:0] e_target = 0;

    task automatic touch(input int e);
        for (int k = 0; k < lru.size(); k++)
            if (lru[k] == e) begin
                lru.delete(k);
                break;
            end
        lru.push_front(e);
    endtask

    always @(posedge clk) begin : model_p
        int li, ui, vic;
        bit lh, uh;
        if (reset) begin
            lru.delete();
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
                lru.push_back(i);
            end
            e_valid = 0; e_hit = 0; e_taken = 0; e_target = 0;
        end else begin
            lh = 0; uh = 0; li = 0; ui = 0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_valid[i] && m_tag[i] == lookup_pc) begin lh = 1; li = i; end
                if (m_valid[i] && m_tag[i] == upd_pc)    begin uh = 1; ui = i; end
            end
            vic = -1;
            for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
            if (vic < 0) vic = lru[$];
            e_valid  = lookup_valid;
            e_hit    = lookup_valid && lh;
            e_target = e_hit ? m_target[li] : 32'h0;
`ifdef BTB_DIRCTR_EN
            e_taken  = e_hit && (m_ctr[li] >= 2);
`else
            e_taken  = e_hit;
`endif
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else begin
                if (e_hit) touch(li);
                if (upd_valid && uh) begin
`ifdef BTB_DIRCTR_EN
                    if (upd_taken) begin
                        m_target[ui] = upd_target;
                        if (m_ctr[ui] < 3) m_ctr[ui]++;
                    end else if (m_ctr[ui] > 0) m_ctr[ui]--;
                    touch(ui);
`else
                    if (upd_taken) begin
                        m_target[ui] = upd_target;
                        touch(ui);
                    end else m_valid[ui] = 0;
`endif
                end else if (upd_valid && upd_taken) begin
                    m_valid[vic]  = 1;
                    m_tag[vic]    = upd_pc;
                    m_target[vic] = upd_target;
                    m_ctr[vic]    = 2;
                    touch(vic);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_pred_valid",  pred_valid,  e_valid);
        chk("cyc_pred_hit",    pred_hit,    e_hit);
        chk("cyc_pred_taken",  pred_taken,  e_taken);
        chk("cyc_pred_target", pred_target, e_target);
    end

    task automatic cyc(input bit lv, input logic [7:0] lpc, input bit uv, input logic [7:0] upc,
                       input bit ut, input logic [31:0] tgt, input bit fl);
        lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = tgt;
        flush = fl;
        @(negedge clk);
        lookup_valid = 0; upd_valid = 0; flush = 0;
        $display("txn lv=%0b lpc=%h uv=%0b upc=%h ut=%0b tgt=%h fl=%0b -> v=%0b hit=%0b tk=%0b tgt=%h",
                 lv, lpc, uv, upc, ut, tgt, fl, pred_valid, pred_hit, pred_taken, pred_target);
    endtask

    task automatic look(input logic [7:0] pc);
        cyc(1, pc, 0, 8'h0, 0, 32'h0, 0);
    endtask

    task automatic upd(input logic [7:0] pc, input bit t, input logic [31:0] tgt);
        cyc(0, 8'h0, 1, pc, t, tgt, 0);
    endtask

    task automatic expect_pred(input string nm, input bit hit, input bit taken, input logic [31:0] tgt);
        chk({nm, "_valid"},  pred_valid,  1);
        chk({nm, "_hit"},    pred_hit,    hit);
        chk({nm, "_taken"},  pred_taken,  taken);
        chk({nm, "_target"}, pred_target, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with a lookup pending: outputs must stay cleared.
        lookup_valid = 1; lookup_pc = 8'h08;
        @(negedge clk);
        chk("rst_valid", pred_valid, 0);
        chk("rst_hit", pred_hit, 0);
        chk("rst_target", pred_target, 0);
        @(negedge clk);
        reset = 0; lookup_valid = 0;

        look(8'h08);
        expect_pred("t1_miss", 0, 0, 32'h0);
        upd(8'h08, 1, 32'h40);
        look(8'h08);
        expect_pred("t2_hit", 1, 1, 32'h40);

`ifdef BTB_DIRCTR_EN
        upd(8'h08, 0, 32'h0);
        upd(8'h08, 0, 32'h0);
        look(8'h08);
        expect_pred("t4_ctr00", 1, 0, 32'h40);
        repeat (3) upd(8'h08, 1, 32'h40);
        look(8'h08);
        expect_pred("t4_ctr11", 1, 1, 32'h40);
        upd(8'h08, 0, 32'h0);
        look(8'h08);
        expect_pred("t4_ctr10", 1, 1, 32'h40);
`else
        upd(8'h08, 0, 32'h0);
        look(8'h08);
        expect_pred("t4_inval", 0, 0, 32'h0);
`endif

        reset = 1;
        @(negedge clk);
        reset = 0;
        look(8'h08);
        expect_pred("t3_after_rst", 0, 0, 32'h0);
        upd(8'h10, 1, 32'h100);
        upd(8'h20, 1, 32'h200);
        upd(8'h30, 1, 32'h300);
        upd(8'h40, 1, 32'h400);
        look(8'h10);
        expect_pred("t3_hit10", 1, 1, 32'h100);
        upd(8'h50, 1, 32'h500);
        look(8'h20);
        expect_pred("t3_evict20", 0, 0, 32'h0);
        look(8'h10);
        expect_pred("t3_keep10", 1, 1, 32'h100);
        look(8'h50);
        expect_pred("t3_hit50", 1, 1, 32'h500);

        // Same-edge lookup and taken update of one entry: old target returned.
        cyc(1, 8'h30, 1, 8'h30, 1, 32'h99, 0);
        expect_pred("t5_old", 1, 1, 32'h300);
        look(8'h30);
        expect_pred("t5_new", 1, 1, 32'h99);
        upd(8'h60, 1, 32'h600);
        upd(8'h70, 1, 32'h700);
        look(8'h30);
        expect_pred("t5_mru_kept", 1, 1, 32'h99);
        look(8'h10);
        expect_pred("t5_evict10", 0, 0, 32'h0);
        look(8'h40);
        expect_pred("t5_evict40", 0, 0, 32'h0);

        // Lookup hits the LRU entry while an allocation replaces it.
        cyc(1, 8'h50, 1, 8'h80, 1, 32'h800, 0);
        expect_pred("alloc_over_lookup", 1, 1, 32'h500);
        look(8'h50);
        expect_pred("alloc_gone50", 0, 0, 32'h0);
        look(8'h80);
        expect_pred("alloc_hit80", 1, 1, 32'h800);

        cyc(1, 8'h70, 0, 8'h0, 0, 32'h0, 1);
        expect_pred("t6_flush_same", 1, 1, 32'h700);
        look(8'h70);
        expect_pred("t6_flushed70", 0, 0, 32'h0);
        look(8'h30);
        expect_pred("t6_flushed30", 0, 0, 32'h0);
        cyc(0, 8'h0, 1, 8'h90, 1, 32'h900, 1);
        look(8'h90);
        expect_pred("t6_upd_ignored", 0, 0, 32'h0);

        // Mixed traffic, checked by the model.
        cyc(1, 8'h70, 1, 8'h90, 1, 32'h900, 0);
        cyc(1, 8'h90, 1, 8'h30, 0, 32'h0, 0);
        cyc(1, 8'h90, 1, 8'ha0, 1, 32'ha00, 0);
        cyc(1, 8'ha0, 1, 8'hb0, 1, 32'hb00, 0);
        cyc(1, 8'h90, 1, 8'hc0, 1, 32'hc00, 0);
        cyc(1, 8'hb0, 1, 8'hd0, 1, 32'hd00, 0);
        cyc(1, 8'hc0, 1, 8'hc0, 0, 32'h0, 0);
        cyc(1, 8'hd0, 1, 8'hd0, 1, 32'hd0d, 0);
        cyc(1, 8'ha0, 1, 8'he0, 1, 32'he00, 0);
        for (int k = 0; k < 8; k++) look(8'h90 + 8'(k * 16));

        // Reset during back-to-back lookups.
        upd(8'h11, 1, 32'h111);
        lookup_valid = 1; lookup_pc = 8'h11;
        @(negedge clk);
        expect_pred("mid_before", 1, 1, 32'h111);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_valid", pred_valid, 0);
        chk("mid_rst_hit", pred_hit, 0);
        reset = 0;
        @(negedge clk);
        expect_pred("mid_after", 0, 0, 32'h0);
        lookup_valid = 0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btb_assoc_lru.md
Name: btb_assoc_lru

Overview:
- Parametrised fully-associative branch target buffer for the pipelined ARM core, ENTRIES deep.
- Fetch stage issues a PC lookup; the block returns a registered hit/target/direction prediction one cycle later.
- Execute stage writes back resolved branches.
- Adds over the previous BTB: valid bits, true LRU replacement, per-entry 2-bit direction counters, flush, and in-place target update.

Parameters:
- ENTRIES, 4, number of BTB entries (2..16).
- TAG_W, 8, PC bits compared as tag (PC[TAG_W-1:0]).
- TARGET_W, 32, branch target address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  invalidate all entries next edge.
- lookup_valid  in  1  fetch lookup request this cycle.
- lookup_pc  in  TAG_W  fetch PC tag.
- pred_valid  out  1  registered: lookup_valid delayed one cycle.
- pred_hit  out  1  registered: lookup matched a valid entry.
- pred_taken  out  1  registered: hit and predicted taken.
- pred_target  out  TARGET_W  registered target; 0 when not hit.
- upd_valid  in  1  resolved branch write-back from execute.
- upd_pc  in  TAG_W  tag of resolved branch (branch's own PC, not PC+4).
- upd_taken  in  1  actual outcome.
- upd_target  in  TARGET_W  actual target (ALU branch address).

Behaviour:
- Reset: all valid=0, all counters=2'b01, LRU ranks = entry index (entry 0 MRU). pred_valid, pred_hit, pred_taken=0; pred_target=0.
- reset has priority over flush, lookup and update.
- Entry state: valid, tag[TAG_W], target[TARGET_W], ctr[2], rank[clog2(ENTRIES)]. Ranks are always a permutation of 0..ENTRIES-1; 0 = MRU.
- Lookup, latency 1:
  - At the edge where lookup_valid=1, match lookup_pc against all valid tags using pre-edge state.
  - Next cycle: pred_valid=1, pred_hit=match, pred_target=target or 0, pred_taken=hit & ctr[1].
  - lookup_valid=0: pred_valid=pred_hit=pred_taken=0, pred_target=0.
- Lookup hit promotes the entry to rank 0; entries with smaller rank shift +1.
- Update, upd_valid=1, matches against pre-edge state:
  - Hit: ctr saturating +1 if taken, -1 if not (floor 00, ceiling 11). If taken, target <= upd_target. Entry promoted to MRU.
  - Miss and taken: allocate lowest-index invalid entry; if none, the entry with rank ENTRIES-1. Write valid=1, tag, target, ctr=2'b10, promote to MRU.
  - Miss and not taken: no change.
- Same-edge lookup and update:
  - Lookup result uses pre-edge contents.
  - LRU applies lookup promotion first, then update promotion, so the updated/allocated entry ends MRU and the lookup entry rank 1 (when different).
  - If both hit the same entry, single promotion.
  - If the update allocates over the entry the lookup hit, the lookup still returns the old target.
- flush=1: all valid <= 0 at the edge, ranks and counters untouched. A same-edge lookup still returns its pre-edge result. A same-edge update is ignored.
- Duplicate tags are never created: allocation happens only on a miss.
- Reset asserted mid-stream: next-cycle outputs forced to reset values regardless of lookup_valid.

Optional Feature:
- Macro: BTB_DIRCTR_EN.
- Defined: 2-bit counters implemented as above.
- Undefined: no counter storage. pred_taken = pred_hit. Not-taken update on a hit invalidates that entry (valid<=0, rank unchanged). Taken behaviour unchanged.

Test Plan:
1. Reset, then lookup_pc=0x08 -> next cycle pred_valid=1, pred_hit=0, pred_target=0.
2. Update pc=0x08 taken target=0x00000040, then lookup 0x08 -> pred_hit=1, pred_target=0x40, pred_taken=1 (ctr=10).
3. Fill 4 entries (tags 0x10, 0x20, 0x30, 0x40 in order).
   - Lookup 0x10 to make it MRU, then allocate 0x50 -> tag 0x20 evicted: lookup 0x20 misses, 0x10 still hits.
4. With BTB_DIRCTR_EN: entry 0x08 ctr=10, two not-taken updates -> ctr 00, lookup gives pred_hit=1, pred_taken=0.
   - Three taken updates -> ctr 11, pred_taken=1.
   - Without macro: one not-taken update -> lookup misses.
5. Same-edge lookup 0x30 (hit) and taken update 0x30 target 0x99 -> pred_target = old target. Next lookup returns 0x99, and the entry is MRU.
6. flush with valid entries, then lookup any stored tag -> miss. Reset asserted during back-to-back lookups -> pred_valid=0 the following cycle.
